// File: rtl/id_ex_pipeline_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipeline_reg
//   ID/EX pipeline register sitting directly behind the ID-stage register
//   file. Captures the register-file operands, decoded fields and control
//   bundle for the EX stage. A WB-to-ID bypass covers the case where the
//   register file is written in the same cycle it is read. Supports stall
//   (hold) and flush (bubble), and keeps saturating debug counters for both.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   stall, flush          hold EX contents / insert a bubble (flush wins)
//   id_*                  instruction fields arriving from ID
//   wb_regwrite/
//   wb_writereg/
//   wb_writedata          register-file write happening this cycle
//   ex_*                  registered EX-stage copy of the instruction
//   stall_count           cycles spent holding (saturating)
//   flush_count           bubbles inserted (saturating)
// ---------------------------------------------------------------------------
module id_ex_pipeline_reg #(
    parameter int CTRL_W = 9,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [31:0]       id_pc4,
    input  logic [31:0]       id_readdata1,
    input  logic [31:0]       id_readdata2,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [31:0]       id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              wb_regwrite,
    input  logic [4:0]        wb_writereg,
    input  logic [31:0]       wb_writedata,
    output logic              ex_valid,
    output logic [31:0]       ex_pc4,
    output logic [31:0]       ex_readdata1,
    output logic [31:0]       ex_readdata2,
    output logic [31:0]       ex_imm,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // A WB write targets src this cycle; r0 is hardwired and never forwards.
    function automatic logic wb_hit(input logic       regwrite,
                                    input logic [4:0] writereg,
                                    input logic [4:0] src);
        return regwrite && (writereg != 5'd0) && (writereg == src);
    endfunction

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : (c + CNT_ONE);
    endfunction

    logic              valid_r,  valid_s;
    logic [31:0]       pc4_r,    pc4_s;
    logic [31:0]       rd1_r,    rd1_s;
    logic [31:0]       rd2_r,    rd2_s;
    logic [31:0]       imm_r,    imm_s;
    logic [4:0]        rs_r,     rs_s;
    logic [4:0]        rt_r,     rt_s;
    logic [4:0]        rd_r,     rd_s;
    logic [CTRL_W-1:0] ctrl_r,   ctrl_s;
    logic [CNT_W-1:0]  scnt_r,   scnt_s;
    logic [CNT_W-1:0]  fcnt_r,   fcnt_s;

    logic              load_hit1_s, load_hit2_s;
    logic              hold_hit1_s, hold_hit2_s;

    // Forwarding decisions: load path compares against ID specifiers, the
    // stall path refreshes a held valid entry whose sources are written now.
    always_comb begin
        load_hit1_s = wb_hit(wb_regwrite, wb_writereg, id_rs);
        load_hit2_s = wb_hit(wb_regwrite, wb_writereg, id_rt);
        hold_hit1_s = valid_r && wb_hit(wb_regwrite, wb_writereg, rs_r);
        hold_hit2_s = valid_r && wb_hit(wb_regwrite, wb_writereg, rt_r);
    end

    // Next-state selection with priority flush > stall > load.
    always_comb begin
        valid_s = valid_r;
        pc4_s   = pc4_r;
        rd1_s   = rd1_r;
        rd2_s   = rd2_r;
        imm_s   = imm_r;
        rs_s    = rs_r;
        rt_s    = rt_r;
        rd_s    = rd_r;
        ctrl_s  = ctrl_r;
        scnt_s  = scnt_r;
        fcnt_s  = fcnt_r;
        if (flush) begin
            valid_s = 1'b0;
            pc4_s   = 32'd0;
            rd1_s   = 32'd0;
            rd2_s   = 32'd0;
            imm_s   = 32'd0;
            rs_s    = 5'd0;
            rt_s    = 5'd0;
            rd_s    = 5'd0;
            ctrl_s  = {CTRL_W{1'b0}};
            fcnt_s  = sat_inc(fcnt_r);
        end else if (stall) begin
            // Held operands must still observe writebacks, or the value
            // read earlier goes stale while the entry waits.
            if (hold_hit1_s) begin
                rd1_s = wb_writedata;
            end else begin
                rd1_s = rd1_r;
            end
            if (hold_hit2_s) begin
                rd2_s = wb_writedata;
            end else begin
                rd2_s = rd2_r;
            end
            scnt_s = sat_inc(scnt_r);
        end else begin
            valid_s = id_valid;
            pc4_s   = id_pc4;
            rd1_s   = load_hit1_s ? wb_writedata : id_readdata1;
            rd2_s   = load_hit2_s ? wb_writedata : id_readdata2;
            imm_s   = id_imm;
            rs_s    = id_rs;
            rt_s    = id_rt;
            rd_s    = id_rd;
            // An invalid slot must not carry side-effecting control.
            ctrl_s  = id_valid ? id_ctrl : {CTRL_W{1'b0}};
        end
    end

    // EX-stage state register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            pc4_r   <= 32'd0;
            rd1_r   <= 32'd0;
            rd2_r   <= 32'd0;
            imm_r   <= 32'd0;
            rs_r    <= 5'd0;
            rt_r    <= 5'd0;
            rd_r    <= 5'd0;
            ctrl_r  <= {CTRL_W{1'b0}};
            scnt_r  <= {CNT_W{1'b0}};
            fcnt_r  <= {CNT_W{1'b0}};
        end else begin
            valid_r <= valid_s;
            pc4_r   <= pc4_s;
            rd1_r   <= rd1_s;
            rd2_r   <= rd2_s;
            imm_r   <= imm_s;
            rs_r    <= rs_s;
            rt_r    <= rt_s;
            rd_r    <= rd_s;
            ctrl_r  <= ctrl_s;
            scnt_r  <= scnt_s;
            fcnt_r  <= fcnt_s;
        end
    end

    assign ex_valid     = valid_r;
    assign ex_pc4       = pc4_r;
    assign ex_readdata1 = rd1_r;
    assign ex_readdata2 = rd2_r;
    assign ex_imm       = imm_r;
    assign ex_rs        = rs_r;
    assign ex_rt        = rt_r;
    assign ex_rd        = rd_r;
    assign ex_ctrl      = ctrl_r;
    assign stall_count  = scnt_r;
    assign flush_count  = fcnt_r;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
`timescale 1ns/1ps
module tb_id_ex_pipeline_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, id_valid;
    logic [31:0] id_pc4, id_readdata1, id_readdata2, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [8:0]  id_ctrl;
    logic        wb_regwrite;
    logic [4:0]  wb_writereg;
    logic [31:0] wb_writedata;

    logic        ex_valid;
    logic [31:0] ex_pc4, ex_readdata1, ex_readdata2, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [8:0]  ex_ctrl;
    logic [15:0] stall_count, flush_count;

    // narrow-counter instance, used for saturation checks
    logic        s_valid;
    logic [31:0] s_pc4, s_rd1, s_rd2, s_imm;
    logic [4:0]  s_rs, s_rt, s_rd;
    logic [8:0]  s_ctrl;
    logic [3:0]  s_stall_count, s_flush_count;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    id_ex_pipeline_reg dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_pc4(id_pc4), .id_readdata1(id_readdata1), .id_readdata2(id_readdata2),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .wb_regwrite(wb_regwrite), .wb_writereg(wb_writereg), .wb_writedata(wb_writedata),
        .ex_valid(ex_valid), .ex_pc4(ex_pc4), .ex_readdata1(ex_readdata1),
        .ex_readdata2(ex_readdata2), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .stall_count(stall_count), .flush_count(flush_count)
    );

    id_ex_pipeline_reg #(.CTRL_W(9), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_pc4(id_pc4), .id_readdata1(id_readdata1), .id_readdata2(id_readdata2),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .wb_regwrite(wb_regwrite), .wb_writereg(wb_writereg), .wb_writedata(wb_writedata),
        .ex_valid(s_valid), .ex_pc4(s_pc4), .ex_readdata1(s_rd1),
        .ex_readdata2(s_rd2), .ex_imm(s_imm), .ex_rs(s_rs), .ex_rt(s_rt),
        .ex_rd(s_rd), .ex_ctrl(s_ctrl), .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    // Reference model: what the EX slot should hold, plus raw event counts.
    typedef struct {
        logic        valid;
        logic [31:0] pc4, rd1, rd2, imm;
        logic [4:0]  rs, rt, rd;
        logic [8:0]  ctrl;
        int          stalls, flushes;
    } exp_t;

    exp_t m;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int sat(input int n, input int maxv);
        return (n > maxv) ? maxv : n;
    endfunction

    function automatic bit writes(input logic [4:0] r);
        return wb_regwrite && (wb_writereg != 5'd0) && (wb_writereg == r);
    endfunction

    task automatic model_clear();
        m.valid = 1'b0; m.pc4 = 32'd0; m.rd1 = 32'd0; m.rd2 = 32'd0; m.imm = 32'd0;
        m.rs = 5'd0; m.rt = 5'd0; m.rd = 5'd0; m.ctrl = 9'd0; m.stalls = 0; m.flushes = 0;
    endtask

    // Apply one clock's worth of the pipeline rules to the model.
    task automatic model_step();
        if (flush) begin
            m.valid = 1'b0; m.pc4 = 32'd0; m.rd1 = 32'd0; m.rd2 = 32'd0; m.imm = 32'd0;
            m.rs = 5'd0; m.rt = 5'd0; m.rd = 5'd0; m.ctrl = 9'd0;
            m.flushes++;
        end else if (stall) begin
            if (m.valid && writes(m.rs)) m.rd1 = wb_writedata;
            if (m.valid && writes(m.rt)) m.rd2 = wb_writedata;
            m.stalls++;
        end else begin
            m.valid = id_valid;
            m.pc4 = id_pc4;
            m.rd1 = writes(id_rs) ? wb_writedata : id_readdata1;
            m.rd2 = writes(id_rt) ? wb_writedata : id_readdata2;
            m.imm = id_imm;
            m.rs = id_rs; m.rt = id_rt; m.rd = id_rd;
            m.ctrl = id_valid ? id_ctrl : 9'd0;
        end
    endtask

    // Drive one cycle of stimulus on the falling edge and queue the expectation.
    task automatic drive(input logic st, input logic fl, input logic v,
                         input logic [31:0] pc4, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] imm, input logic [8:0] ctrl,
                         input logic wr, input logic [4:0] wreg, input logic [31:0] wdata);
        @(negedge clk);
        stall = st; flush = fl; id_valid = v; id_pc4 = pc4;
        id_readdata1 = r1; id_readdata2 = r2; id_rs = rs; id_rt = rt; id_rd = rd;
        id_imm = imm; id_ctrl = ctrl;
        wb_regwrite = wr; wb_writereg = wreg; wb_writedata = wdata;
        model_step();
        exp_q.push_back(m);
    endtask

    task automatic drive_rand(input logic st, input logic fl);
        drive(st, fl, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom),
              $urandom, 9'($urandom), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 7)), $urandom);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, {31'd0, ex_valid}, 32'd0);
        check({tag, "_rd1"},   ex_readdata1, 32'd0);
        check({tag, "_rd2"},   ex_readdata2, 32'd0);
        check({tag, "_pc4"},   ex_pc4, 32'd0);
        check({tag, "_imm"},   ex_imm, 32'd0);
        check({tag, "_regs"},  {17'd0, ex_rs, ex_rt, ex_rd}, 32'd0);
        check({tag, "_ctrl"},  {23'd0, ex_ctrl}, 32'd0);
        check({tag, "_scnt"},  {16'd0, stall_count}, 32'd0);
        check({tag, "_fcnt"},  {16'd0, flush_count}, 32'd0);
        check({tag, "_cnt4"},  {24'd0, s_stall_count, s_flush_count}, 32'd0);
    endtask

    // Monitor: every cycle the DUT registers new EX contents, compare them.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ex_valid", {31'd0, ex_valid}, {31'd0, e.valid});
                check("ex_pc4", ex_pc4, e.pc4);
                check("ex_readdata1", ex_readdata1, e.rd1);
                check("ex_readdata2", ex_readdata2, e.rd2);
                check("ex_imm", ex_imm, e.imm);
                check("ex_regs", {17'd0, ex_rs, ex_rt, ex_rd}, {17'd0, e.rs, e.rt, e.rd});
                check("ex_ctrl", {23'd0, ex_ctrl}, {23'd0, e.ctrl});
                check("stall_count", {16'd0, stall_count}, 32'(sat(e.stalls, 65535)));
                check("flush_count", {16'd0, flush_count}, 32'(sat(e.flushes, 65535)));
                check("stall_count4", {28'd0, s_stall_count}, 32'(sat(e.stalls, 15)));
                check("flush_count4", {28'd0, s_flush_count}, 32'(sat(e.flushes, 15)));
                check("ex_valid4", {31'd0, s_valid}, {31'd0, e.valid});
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        stall = 1'b0; flush = 1'b0; id_valid = 1'b0; id_pc4 = 32'd0;
        id_readdata1 = 32'd0; id_readdata2 = 32'd0; id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0;
        id_imm = 32'd0; id_ctrl = 9'd0; wb_regwrite = 1'b0; wb_writereg = 5'd0; wb_writedata = 32'd0;
        model_clear();
        #3;
        check_all_zero("por");
        @(posedge clk);
        #2 rst_n = 1'b1;

        // plain load
        drive(0, 0, 1, 32'h0000_0104, 32'hAAAA_0001, 32'h0000_0022, 5'd3, 5'd4, 5'd9,
              32'hFFFF_FFF0, 9'h1A5, 0, 5'd3, 32'h1111_1111);
        // bypass on both operands, then r0 never bypasses
        drive(0, 0, 1, 32'h0000_0108, 32'd0, 32'd0, 5'd5, 5'd5, 5'd6,
              32'd7, 9'h0F0, 1, 5'd5, 32'hDEAD_BEEF);
        drive(0, 0, 1, 32'h0000_010C, 32'd0, 32'd0, 5'd0, 5'd0, 5'd6,
              32'd8, 9'h00F, 1, 5'd0, 32'h5555_5555);
        // invalid instruction must not carry control
        drive(0, 0, 0, 32'h0000_0110, 32'h1, 32'h2, 5'd1, 5'd2, 5'd3,
              32'd9, 9'h1FF, 0, 5'd0, 32'd0);
        // stall with hold-refresh: load rt=7 / 0x10, then 3 stalls, WB r7 in the 2nd
        drive(0, 0, 1, 32'h0000_0200, 32'h0000_0abc, 32'h0000_0010, 5'd2, 5'd7, 5'd8,
              32'd4, 9'h155, 0, 5'd0, 32'd0);
        drive(1, 0, 1, 32'hFFFF_0000, 32'h3333_3333, 32'h4444_4444, 5'd9, 5'd10, 5'd11,
              32'd1, 9'h0AA, 0, 5'd7, 32'h0000_0077);
        drive(1, 0, 1, 32'hFFFF_0004, 32'h3333_3334, 32'h4444_4445, 5'd12, 5'd13, 5'd14,
              32'd2, 9'h0AB, 1, 5'd7, 32'h0000_0099);
        drive(1, 0, 0, 32'hFFFF_0008, 32'h3333_3335, 32'h4444_4446, 5'd15, 5'd16, 5'd17,
              32'd3, 9'h0AC, 0, 5'd7, 32'h0000_0055);
        // flush beats stall
        drive(1, 1, 1, 32'h0000_0300, 32'h1, 32'h2, 5'd1, 5'd2, 5'd3,
              32'd5, 9'h1A5, 1, 5'd1, 32'h9);

        // asynchronous reset mid-cycle with a live entry
        drive(0, 0, 1, 32'h0000_0400, 32'h0000_1234, 32'h0, 5'd4, 5'd5, 5'd6,
              32'd0, 9'h101, 0, 5'd0, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        model_clear();
        #1 rst_n = 1'b1;

        // saturation: 20 consecutive stalls
        for (int i = 0; i < 20; i++) drive_rand(1'b1, 1'b0);
        @(posedge clk);
        #2;
        check("sat_stall4", {28'd0, s_stall_count}, 32'd15);
        check("sat_stall16", {16'd0, stall_count}, 32'd20);

        // flush saturation of the narrow counter
        for (int i = 0; i < 18; i++) drive_rand(1'b0, 1'b1);

        // randomized mix
        for (int i = 0; i < 600; i++)
            drive_rand(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0));

        repeat (4) @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
